// File: rtl/lv_owt_acc_sched.sv
// One-wire register access scheduler: arbitrates SPI and watchdog-scan requests onto one link.
// Latency: request to ack is 4 cycles minimum (IDLE, ISSUE, WAIT_RSP, DONE); retries add ISSUE+WAIT.
// Backpressure: frame held in ISSUE until i_owt_tx_rdy; requesters hold level requests until ack.
module lv_owt_acc_sched #(
   parameter int REG_AW     = 7,
   parameter int REG_DW     = 8,
   parameter int TMO_CYC    = 255,
   parameter int MAX_RETRY  = 2,
   parameter int STARVE_LMT = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_spi_owt_wr_req,
   input  logic              i_spi_owt_rd_req,
   input  logic [REG_AW-1:0] i_spi_owt_addr,
   input  logic [REG_DW-1:0] i_spi_owt_data,
   output logic              o_owt_spi_wack,
   output logic              o_owt_spi_rack,
   output logic [REG_DW-1:0] o_owt_spi_rdata,
   output logic              o_owt_spi_err,
   input  logic              i_scan_owt_rd_req,
   input  logic [REG_AW-1:0] i_scan_owt_addr,
   output logic              o_owt_scan_ack,
   output logic [REG_DW-1:0] o_owt_scan_rdata,
   output logic              o_owt_scan_err,
   output logic              o_owt_tx_vld,
   output logic              o_owt_tx_wr,
   output logic [REG_AW-1:0] o_owt_tx_addr,
   output logic [REG_DW-1:0] o_owt_tx_data,
   input  logic              i_owt_tx_rdy,
   input  logic              i_owt_rx_vld,
   input  logic [REG_DW-1:0] i_owt_rx_data,
   input  logic              i_owt_rx_err,
   input  logic              i_err_clr,
   output logic              o_owt_tmo_err,
   output logic              o_owt_busy
);

   localparam int TW = $clog2(TMO_CYC + 1);
   localparam int RW = (MAX_RETRY  > 0) ? $clog2(MAX_RETRY + 1)  : 1;
   localparam int SW = (STARVE_LMT > 0) ? $clog2(STARVE_LMT + 1) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_t;

   state_t            state_q, state_d;
   logic              wr_q, wr_d;         // granted transaction is a write
   logic              scan_q, scan_d;     // granted requester is the scan path
   logic [REG_AW-1:0] addr_q, addr_d;
   logic [REG_DW-1:0] data_q, data_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [RW-1:0]     retry_q, retry_d;
   logic              fail_q, fail_d;
   logic [REG_DW-1:0] spi_rdata_q, spi_rdata_d;
   logic [REG_DW-1:0] scan_rdata_q, scan_rdata_d;
   logic              tmo_err_q, tmo_err_d;
   logic              set_err;

   logic spi_pend;
   logic scan_pend;
   logic scan_wins;
   logic rsp_ok;
   logic att_fail;

   assign spi_pend  = i_spi_owt_wr_req | i_spi_owt_rd_req;
   assign scan_pend = i_scan_owt_rd_req;
   // Scan only beats a pending SPI request once SPI has starved it STARVE_LMT times in a row.
   assign scan_wins = scan_pend & (~spi_pend | (starve_q == SW'(STARVE_LMT)));
   // A good response on the timeout cycle still counts as success.
   assign rsp_ok    = i_owt_rx_vld & ~i_owt_rx_err;
   assign att_fail  = (i_owt_rx_vld & i_owt_rx_err) |
                      (~i_owt_rx_vld & (tmo_q == TW'(TMO_CYC - 1)));

   // Next-state, arbitration, retry and response-capture logic.
   always_comb begin
      state_d      = state_q;
      wr_d         = wr_q;
      scan_d       = scan_q;
      addr_d       = addr_q;
      data_d       = data_q;
      starve_d     = starve_q;
      tmo_d        = tmo_q;
      retry_d      = retry_q;
      fail_d       = fail_q;
      spi_rdata_d  = spi_rdata_q;
      scan_rdata_d = scan_rdata_q;
      set_err      = 1'b0;
      case (state_q)
         IDLE: begin
            if (scan_wins) begin
               scan_d   = 1'b1;
               wr_d     = 1'b0;
               addr_d   = i_scan_owt_addr;
               data_d   = '0;
               starve_d = '0;
               state_d  = ISSUE;
            end else if (spi_pend) begin
               // Write wins a simultaneous read; the read is re-seen on a later IDLE.
               scan_d  = 1'b0;
               wr_d    = i_spi_owt_wr_req;
               addr_d  = i_spi_owt_addr;
               data_d  = i_spi_owt_data;
               state_d = ISSUE;
               if (!scan_pend) begin
                  starve_d = '0;
               end else if (starve_q != SW'(STARVE_LMT)) begin
                  starve_d = starve_q + SW'(1);
               end
            end else begin
               starve_d = '0;
            end
         end
         ISSUE: begin
            if (i_owt_tx_rdy) begin
               tmo_d   = '0;
               state_d = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            tmo_d = tmo_q + TW'(1);
            if (rsp_ok) begin
               fail_d  = 1'b0;
               state_d = DONE;
               if (scan_q) begin
                  scan_rdata_d = i_owt_rx_data;
               end else if (!wr_q) begin
                  spi_rdata_d = i_owt_rx_data;
               end
            end else if (att_fail) begin
               if (retry_q < RW'(MAX_RETRY)) begin
                  retry_d = retry_q + RW'(1);
                  state_d = ISSUE;
               end else begin
                  fail_d  = 1'b1;
                  set_err = 1'b1;
                  state_d = DONE;
                  if (scan_q) begin
                     scan_rdata_d = '0;
                  end else if (!wr_q) begin
                     spi_rdata_d = '0;
                  end
               end
            end
         end
         DONE: begin
            retry_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A failure landing in the same cycle as a clear keeps the flag set.
      if (set_err) begin
         tmo_err_d = 1'b1;
      end else if (i_err_clr) begin
         tmo_err_d = 1'b0;
      end else begin
         tmo_err_d = tmo_err_q;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= IDLE;
         wr_q         <= 1'b0;
         scan_q       <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         starve_q     <= '0;
         tmo_q        <= '0;
         retry_q      <= '0;
         fail_q       <= 1'b0;
         spi_rdata_q  <= '0;
         scan_rdata_q <= '0;
         tmo_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_q         <= wr_d;
         scan_q       <= scan_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         starve_q     <= starve_d;
         tmo_q        <= tmo_d;
         retry_q      <= retry_d;
         fail_q       <= fail_d;
         spi_rdata_q  <= spi_rdata_d;
         scan_rdata_q <= scan_rdata_d;
         tmo_err_q    <= tmo_err_d;
      end
   end

   assign o_owt_busy       = (state_q != IDLE);
   assign o_owt_tx_vld     = (state_q == ISSUE);
   assign o_owt_tx_wr      = wr_q;
   assign o_owt_tx_addr    = addr_q;
   assign o_owt_tx_data    = data_q;
   assign o_owt_spi_wack   = (state_q == DONE) & ~scan_q & wr_q;
   assign o_owt_spi_rack   = (state_q == DONE) & ~scan_q & ~wr_q;
   assign o_owt_scan_ack   = (state_q == DONE) & scan_q;
   assign o_owt_spi_err    = (state_q == DONE) & ~scan_q & fail_q;
   assign o_owt_scan_err   = (state_q == DONE) & scan_q & fail_q;
   assign o_owt_spi_rdata  = spi_rdata_q;
   assign o_owt_scan_rdata = scan_rdata_q;
   assign o_owt_tmo_err    = tmo_err_q;

endmodule

// File: tb/tb_lv_owt_acc_sched.sv
// Directed bench for lv_owt_acc_sched with default parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
// Link responder is scripted inline per scenario.
module tb_lv_owt_acc_sched;

   localparam int AW = 7;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          spi_wr, spi_rd;
   logic [AW-1:0] spi_addr;
   logic [DW-1:0] spi_data;
   logic          wack, rack, spi_err;
   logic [DW-1:0] spi_rdata;
   logic          scan_rd;
   logic [AW-1:0] scan_addr;
   logic          scan_ack, scan_err;
   logic [DW-1:0] scan_rdata;
   logic          tx_vld, tx_wr, tx_rdy;
   logic [AW-1:0] tx_addr;
   logic [DW-1:0] tx_data;
   logic          rx_vld, rx_err, err_clr;
   logic [DW-1:0] rx_data;
   logic          tmo_err, busy;

   int errs   = 0;
   int checks = 0;

   int            ngrant, nrack, nscan, ntx, rack_at;
   logic [AW-1:0] gaddr [5];
   int            txat [3];

   always #5 clk = ~clk;

   lv_owt_acc_sched dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_spi_owt_wr_req  (spi_wr),
      .i_spi_owt_rd_req  (spi_rd),
      .i_spi_owt_addr    (spi_addr),
      .i_spi_owt_data    (spi_data),
      .o_owt_spi_wack    (wack),
      .o_owt_spi_rack    (rack),
      .o_owt_spi_rdata   (spi_rdata),
      .o_owt_spi_err     (spi_err),
      .i_scan_owt_rd_req (scan_rd),
      .i_scan_owt_addr   (scan_addr),
      .o_owt_scan_ack    (scan_ack),
      .o_owt_scan_rdata  (scan_rdata),
      .o_owt_scan_err    (scan_err),
      .o_owt_tx_vld      (tx_vld),
      .o_owt_tx_wr       (tx_wr),
      .o_owt_tx_addr     (tx_addr),
      .o_owt_tx_data     (tx_data),
      .i_owt_tx_rdy      (tx_rdy),
      .i_owt_rx_vld      (rx_vld),
      .i_owt_rx_data     (rx_data),
      .i_owt_rx_err      (rx_err),
      .i_err_clr         (err_clr),
      .o_owt_tmo_err     (tmo_err),
      .o_owt_busy        (busy)
   );

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; spi_wr = 1'b0; spi_rd = 1'b0; spi_addr = '0; spi_data = '0;
      scan_rd = 1'b0; scan_addr = '0; tx_rdy = 1'b0; rx_vld = 1'b0; rx_data = '0;
      rx_err = 1'b0; err_clr = 1'b0;
      step(); step();

      // Reset state
      chk("rst_busy", busy, 0);
      chk("rst_tx_vld", tx_vld, 0);
      chk("rst_tx_addr", tx_addr, 0);
      chk("rst_acks", {wack, rack, scan_ack}, 0);
      chk("rst_tmo_err", tmo_err, 0);
      chk("rst_rdata", {spi_rdata, scan_rdata}, 0);
      rst = 1'b0;
      step();
      chk("idle_busy", busy, 0);

      // SPI write 0x41/0x5A; link stalls one extra cycle, response 3 cycles into wait
      spi_wr = 1'b1; spi_addr = 7'h41; spi_data = 8'h5A;
      step();
      chk("wr_tx_vld", tx_vld, 1);
      chk("wr_tx_wr", tx_wr, 1);
      chk("wr_tx_addr", tx_addr, 8'h41);
      chk("wr_tx_data", tx_data, 8'h5A);
      spi_wr = 1'b0;
      step();
      chk("wr_hold_vld", tx_vld, 1);
      chk("wr_hold_addr", tx_addr, 8'h41);
      tx_rdy = 1'b1;
      step();
      chk("wr_wait_vld", tx_vld, 0);
      chk("wr_wait_busy", busy, 1);
      step(); step();
      rx_vld = 1'b1;
      step();
      rx_vld = 1'b0;
      chk("wr_wack", wack, 1);
      chk("wr_err", spi_err, 0);
      chk("wr_other_acks", {rack, scan_ack}, 0);
      step();
      chk("wr_wack_once", wack, 0);
      chk("wr_idle_busy", busy, 0);

      // Minimum latency read; rx_vld held high while outside WAIT_RSP is ignored
      spi_rd = 1'b1; spi_addr = 7'h11; rx_vld = 1'b1; rx_data = 8'h33;
      step();
      chk("lat_tx_vld", tx_vld, 1);
      chk("lat_tx_wr", tx_wr, 0);
      spi_rd = 1'b0;
      step();
      chk("lat_no_early_ack", rack, 0);
      step();
      chk("lat_rack", rack, 1);
      chk("lat_rdata", spi_rdata, 8'h33);
      rx_vld = 1'b0;
      step();
      chk("lat_idle", busy, 0);

      // Write and read together: write first, read as a later transaction
      spi_wr = 1'b1; spi_rd = 1'b1; spi_addr = 7'h30; spi_data = 8'h77;
      rx_vld = 1'b1; rx_data = 8'h44;
      step();
      chk("wrd_first_wr", tx_wr, 1);
      chk("wrd_first_data", tx_data, 8'h77);
      spi_wr = 1'b0;
      step(); step();
      chk("wrd_wack", {wack, rack}, 2'b10);
      step(); step();
      chk("wrd_second_vld", tx_vld, 1);
      chk("wrd_second_rd", tx_wr, 0);
      spi_rd = 1'b0;
      step(); step();
      chk("wrd_rack", {wack, rack}, 2'b01);
      chk("wrd_rdata", spi_rdata, 8'h44);
      rx_vld = 1'b0;
      step();

      // Starvation: SPI read and scan both pending -> 4 SPI grants, then scan
      spi_rd = 1'b1; spi_addr = 7'h10; scan_rd = 1'b1; scan_addr = 7'h20;
      rx_vld = 1'b1; rx_data = 8'h5C;
      ngrant = 0; nrack = 0; nscan = 0;
      for (int i = 1; i <= 24; i++) begin
         step();
         if (tx_vld) begin
            if (ngrant < 5) gaddr[ngrant] = tx_addr;
            ngrant++;
         end
         if (rack) nrack++;
         if (scan_ack) nscan++;
         if (i == 17) begin
            spi_rd = 1'b0; scan_rd = 1'b0;
         end
      end
      rx_vld = 1'b0;
      chk("stv_grants", ngrant, 5);
      chk("stv_g0", gaddr[0], 7'h10);
      chk("stv_g1", gaddr[1], 7'h10);
      chk("stv_g2", gaddr[2], 7'h10);
      chk("stv_g3", gaddr[3], 7'h10);
      chk("stv_g4_scan", gaddr[4], 7'h20);
      chk("stv_racks", nrack, 4);
      chk("stv_scan_acks", nscan, 1);
      chk("stv_scan_rdata", scan_rdata, 8'h5C);
      step();

      // rx_err on first attempt, good 0xA3 on retry
      spi_rd = 1'b1; spi_addr = 7'h22;
      step();
      chk("rtr_tx1", tx_vld, 1);
      spi_rd = 1'b0;
      step();
      rx_vld = 1'b1; rx_err = 1'b1;
      step();
      chk("rtr_tx2", tx_vld, 1);
      chk("rtr_no_ack", rack, 0);
      rx_vld = 1'b0; rx_err = 1'b0;
      step();
      rx_vld = 1'b1; rx_data = 8'hA3;
      step();
      rx_vld = 1'b0;
      chk("rtr_rack", rack, 1);
      chk("rtr_rdata", spi_rdata, 8'hA3);
      chk("rtr_err", spi_err, 0);
      chk("rtr_tmo_err", tmo_err, 0);
      step();

      // No response: 3 frames 256 cycles apart, failure, sticky error (set beats clear)
      spi_rd = 1'b1; spi_addr = 7'h0C;
      ntx = 0; rack_at = 0;
      for (int i = 1; i <= 775; i++) begin
         step();
         if (i == 1) spi_rd = 1'b0;
         if (tx_vld) begin
            if (ntx < 3) txat[ntx] = i;
            ntx++;
            chk("tmo_tx_addr", tx_addr, 7'h0C);
         end
         if (i == 768) chk("tmo_err_pre", tmo_err, 0);
         if (rack) begin
            rack_at = i;
            chk("tmo_rack_err", spi_err, 1);
            chk("tmo_rack_rdata", spi_rdata, 0);
            chk("tmo_err_set_wins", tmo_err, 1);
         end
         err_clr = (i == 768);
      end
      chk("tmo_frames", ntx, 3);
      chk("tmo_tx0_at", txat[0], 1);
      chk("tmo_tx1_at", txat[1], 257);
      chk("tmo_tx2_at", txat[2], 513);
      chk("tmo_rack_at", rack_at, 769);
      chk("tmo_err_sticky", tmo_err, 1);
      chk("tmo_idle", busy, 0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("tmo_err_cleared", tmo_err, 0);

      // Response on the last wait cycle beats the timeout
      spi_rd = 1'b1; spi_addr = 7'h55; ntx = 0;
      for (int i = 1; i <= 256; i++) begin
         step();
         if (i == 1) spi_rd = 1'b0;
         if (tx_vld) ntx++;
         if (i == 256) begin
            rx_vld = 1'b1; rx_data = 8'h6E;
         end
      end
      step();
      rx_vld = 1'b0;
      chk("edge_frames", ntx, 1);
      chk("edge_rack", rack, 1);
      chk("edge_err", spi_err, 0);
      chk("edge_rdata", spi_rdata, 8'h6E);
      chk("edge_tmo_err", tmo_err, 0);
      step();

      // Reset during WAIT_RSP aborts; later rx_vld ignored
      spi_rd = 1'b1; spi_addr = 7'h66;
      step();
      chk("ab_tx", tx_vld, 1);
      spi_rd = 1'b0;
      step();
      chk("ab_wait_busy", busy, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("ab_busy", busy, 0);
      chk("ab_tx_vld", tx_vld, 0);
      chk("ab_tx_addr", tx_addr, 0);
      chk("ab_rdata", {spi_rdata, scan_rdata}, 0);
      rx_vld = 1'b1; rx_data = 8'h99;
      step();
      rx_vld = 1'b0;
      chk("ab_no_ack", {wack, rack, scan_ack}, 0);
      chk("ab_still_idle", busy, 0);
      step();
      chk("ab_no_ack2", {wack, rack, scan_ack}, 0);
      chk("ab_rdata2", spi_rdata, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/lv_owt_acc_sched.md
LV_OWT_ACC_SCHED -- requirements
Module: lv_owt_acc_sched

Interface
REQ-001 Parameters SHALL be: REG_AW, default 7, register address width; REG_DW, default 8, register data width; TMO_CYC, default 255, response timeout in i_clk cycles; MAX_RETRY, default 2, retries after first attempt; STARVE_LMT, default 4, consecutive SPI grants allowed while scan waits.
REQ-002 Ports SHALL be (name direction width meaning):
i_clk  in  1  single clock, all logic rising-edge.
i_rst  in  1  reset, synchronous, active-high.
i_spi_owt_wr_req  in  1  SPI-path write request level.
i_spi_owt_rd_req  in  1  SPI-path read request level.
i_spi_owt_addr  in  REG_AW  SPI-path address.
i_spi_owt_data  in  REG_DW  SPI-path write data.
o_owt_spi_wack  out  1  write done pulse.
o_owt_spi_rack  out  1  read done pulse.
o_owt_spi_rdata  out  REG_DW  read data, valid with rack.
o_owt_spi_err  out  1  failure flag, valid with wack/rack.
i_scan_owt_rd_req  in  1  watchdog scan read request level.
i_scan_owt_addr  in  REG_AW  scan address.
o_owt_scan_ack  out  1  scan done pulse.
o_owt_scan_rdata  out  REG_DW  scan read data, valid with ack.
o_owt_scan_err  out  1  failure flag, valid with scan ack.
o_owt_tx_vld  out  1  link frame request.
o_owt_tx_wr  out  1  1=write frame, 0=read frame.
o_owt_tx_addr  out  REG_AW  frame address.
o_owt_tx_data  out  REG_DW  frame write data.
i_owt_tx_rdy  in  1  link accepts frame when high with tx_vld.
i_owt_rx_vld  in  1  link response pulse (write ack or read data).
i_owt_rx_data  in  REG_DW  response data.
i_owt_rx_err  in  1  response CRC/frame error, valid with rx_vld.
i_err_clr  in  1  clears sticky error.
o_owt_tmo_err  out  1  sticky: a transaction exhausted retries.
o_owt_busy  out  1  FSM not IDLE.

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT_RSP, DONE; one transaction in flight at a time.
REQ-004 IDLE: if any request pending, latch winner's type, address, data into internal registers and go to ISSUE next cycle; requester inputs SHALL be ignored until DONE.
REQ-005 Arbitration SHALL grant SPI over scan, except when scan pending and starve counter == STARVE_LMT, then scan wins.
REQ-006 Starve counter SHALL increment on each SPI grant with scan pending, saturate at STARVE_LMT, clear on scan grant or when scan not pending.
REQ-007 wr_req and rd_req both high SHALL grant write; read request is served as a separate later transaction.
REQ-008 ISSUE: o_owt_tx_vld=1 with latched fields held stable; on tx_vld&tx_rdy go to WAIT_RSP and clear timeout counter; no timeout in ISSUE.
REQ-009 WAIT_RSP: timeout counter increments per cycle; rx_vld&~rx_err -> capture rx_data, go DONE with success.
REQ-010 rx_vld&rx_err, or counter reaching TMO_CYC-1 without rx_vld, SHALL count as failed attempt: if retry count < MAX_RETRY, increment it and return to ISSUE; else go DONE with failure.
REQ-011 rx_vld on the same cycle as timeout SHALL take priority over timeout.
REQ-012 rx_vld outside WAIT_RSP SHALL be ignored.
REQ-013 DONE: exactly one cycle; pulse ack of granted requester (spi wack for write, spi rack for SPI read, scan ack for scan); err output high on that cycle if failure; rdata outputs hold captured data (zero on failure) until next DONE; then IDLE, retry count cleared.
REQ-014 Failure SHALL set o_owt_tmo_err; it holds until i_err_clr; set in same cycle as clear wins.
REQ-015 Minimum transaction latency: request to ack = 4 cycles with tx_rdy and rx_vld immediate (IDLE, ISSUE, WAIT_RSP, DONE).
REQ-016 o_owt_busy SHALL be high in every state except IDLE.
REQ-017 Timeout counter width SHALL be $clog2(TMO_CYC+1); retry counter $clog2(MAX_RETRY+1); no wrap.

Reset
REQ-018 i_rst high at a rising edge SHALL force IDLE, clear all counters, latched fields, rdata and sticky error; all outputs 0 next cycle.
REQ-019 Reset mid-transaction SHALL abort without ack; a later rx_vld SHALL be ignored.

Verification
REQ-020 SPI write addr 0x41 data 0x5A, tx_rdy=1, rx_vld 3 cycles later -> tx_wr=1, addr 0x41, data 0x5A; one wack pulse, err=0.
REQ-021 SPI read and scan read pending together, STARVE_LMT=4 -> SPI granted 4 times back-to-back, 5th grant goes to scan.
REQ-022 Read addr 0x0C, no rx_vld -> 3 tx frames, each after 255 wait cycles; rack with err=1, rdata=0, tmo_err=1 until i_err_clr.
REQ-023 Read with rx_err on first attempt, good rx_data 0xA3 on second -> rack, rdata 0xA3, err=0, tmo_err stays 0.
REQ-024 Assert i_rst during WAIT_RSP, then rx_vld -> no ack, busy=0, outputs zero.
REQ-025 rx_vld on cycle TMO_CYC-1 of WAIT_RSP -> success, no retry.
